// File: rtl/conv_acc_pkg.sv
// Shared constants, FSM state type and the shift/saturate helper for the conv accumulator
// and the pooling stage.
package conv_acc_pkg;

    localparam int N_KERN = 4;
    localparam int N_TAP  = 9;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Arithmetic shift, optional rectification, then clamp to a signed out_w-bit range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] v,
        input int                 shift,
        input int                 out_w,
        input logic               relu
    );
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = v >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (relu && (y < 64'sd0)) begin
            y = 64'sd0;
        end
        if (y > hi) begin
            y = hi;
        end else if (y < lo) begin
            y = lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/conv_acc_lane.sv
// One output-channel lane: 9-tap adder, stage-A register, channel accumulator and
// post-processing. Rectification is enabled by defining CONV_ACC_RELU_EN.
module conv_acc_lane
    import conv_acc_pkg::*;
#(
    parameter int PROD_W = 25,
    parameter int ACC_W  = 38,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic                    drain,
    input  logic [N_TAP*PROD_W-1:0] prod,
    output logic [OUT_W-1:0]        out_data
);

    localparam int SUM_W = PROD_W + 4;

`ifdef CONV_ACC_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic signed [SUM_W-1:0] tap_ext [N_TAP];
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] sum_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] final_sum;
    logic        [OUT_W-1:0] out_reg;

    for (genvar gi = 0; gi < N_TAP; gi++) begin : g_tap
        assign tap_ext[gi] = {{4{prod[(gi+1)*PROD_W-1]}}, prod[gi*PROD_W +: PROD_W]};
    end

    always_comb begin
        sum_next = '0;
        for (int t = 0; t < N_TAP; t++) begin
            sum_next = sum_next + tap_ext[t];
        end
    end

    // Running total including the beat currently sitting in stage A.
    assign final_sum = acc_reg + ACC_W'(sum_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
            acc_reg <= '0;
            out_reg <= '0;
        end else begin
            if (load) begin
                sum_reg <= sum_next;
            end
            if (drain) begin
                acc_reg <= '0;
                out_reg <= OUT_W'(sat_shift(64'(final_sum), SHIFT, OUT_W, RELU));
            end else if (acc_en) begin
                acc_reg <= final_sum;
            end
        end
    end

    assign out_data = out_reg;

endmodule

// File: rtl/conv_acc_stage.sv
// 4-lane channel accumulator behind the PE array: sums taps, accumulates channels, hands
// rescaled pixels to write-back. Optional ReLU via CONV_ACC_RELU_EN.
module conv_acc_stage
    import conv_acc_pkg::*;
#(
    parameter int PROD_W = 25,
    parameter int ACC_W  = 38,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [N_KERN*N_TAP*PROD_W-1:0] in_prod,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_KERN*OUT_W-1:0]        out_data
);

    state_t state_reg;
    logic   a_valid_reg;
    logic   a_last_reg;
    logic   accept;
    logic   acc_en;
    logic   drain;

    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign accept    = in_valid && in_ready;
    // The last beat of a group is folded in by the drain, not the accumulator.
    assign acc_en    = a_valid_reg && !a_last_reg;
    assign drain     = (state_reg == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ACC;
            a_valid_reg <= 1'b0;
            a_last_reg  <= 1'b0;
        end else begin
            a_valid_reg <= accept;
            a_last_reg  <= accept && in_last;
            case (state_reg)
                ACC: begin
                    if (accept && in_last) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_reg <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACC;
                    end
                end
                default: begin
                    state_reg <= ACC;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_KERN; gi++) begin : g_lane
        conv_acc_lane #(
            .PROD_W (PROD_W),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W),
            .SHIFT  (SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (accept),
            .acc_en   (acc_en),
            .drain    (drain),
            .prod     (in_prod[gi*N_TAP*PROD_W +: N_TAP*PROD_W]),
            .out_data (out_data[gi*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_conv_acc_stage.sv
// Bench for conv_acc_stage: one instance at SHIFT=8 and one at SHIFT=0 fed identical beats.
module tb_conv_acc_stage;

    localparam int PROD_W = 25;
    localparam int OUT_W  = 16;
    localparam int NK     = 4;
    localparam int NT     = 9;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_last = 1'b0;
    logic                    out_ready = 1'b0;
    logic [NK*NT*PROD_W-1:0] in_prod = '0;
    logic                    in_ready_s8, out_valid_s8, in_ready_s0, out_valid_s0;
    logic [NK*OUT_W-1:0]     out_data_s8, out_data_s0;

    int     prod [NK][NT];
    longint model_sum [NK];
    int     n_pass = 0;
    int     n_total = 0;

    always #5 clk = ~clk;

    conv_acc_stage u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s8),
        .in_last(in_last), .in_prod(in_prod), .out_valid(out_valid_s8),
        .out_ready(out_ready), .out_data(out_data_s8)
    );

    conv_acc_stage #(.SHIFT(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s0),
        .in_last(in_last), .in_prod(in_prod), .out_valid(out_valid_s0),
        .out_ready(out_ready), .out_data(out_data_s0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference pixel: plain arithmetic on the exact channel total.
    function automatic logic [15:0] ref_pixel(input longint s, input int shift);
        longint y;
        y = s >>> shift;
`ifdef CONV_ACC_RELU_EN
        if (y < 0) y = 0;
`endif
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y[15:0];
    endfunction

    function automatic logic [63:0] ref_word(input int shift);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < NK; k++) w[k*16 +: 16] = ref_pixel(model_sum[k], shift);
        return w;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NK; k++) model_sum[k] = 0;
    endtask

    task automatic set_const(input int v0, input int v1, input int v2, input int v3);
        for (int t = 0; t < NT; t++) begin
            prod[0][t] = v0; prod[1][t] = v1; prod[2][t] = v2; prod[3][t] = v3;
        end
    endtask

    task automatic set_rand();
        for (int k = 0; k < NK; k++)
            for (int t = 0; t < NT; t++)
                prod[k][t] = int'($urandom_range(0, 33554431)) - 16777216;
    endtask

    // Garbage on the data lines while in_valid is low must be ignored.
    task automatic scramble();
        for (int i = 0; i < NK*NT; i++) in_prod[i*PROD_W +: PROD_W] = PROD_W'($urandom);
        in_last = 1'($urandom_range(0, 1));
    endtask

    task automatic beat(input logic last, input string tag);
        for (int k = 0; k < NK; k++)
            for (int t = 0; t < NT; t++) begin
                in_prod[(k*NT+t)*PROD_W +: PROD_W] = prod[k][t][PROD_W-1:0];
                model_sum[k] += longint'(prod[k][t]);
            end
        in_last  = last;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'({in_ready_s8, in_ready_s0}), 64'h3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            scramble();
        end
    endtask

    // Called one step after the edge that accepted the last beat.
    task automatic finish_group(input int hold, input string tag);
        logic [63:0] exp8, exp0;
        exp8 = ref_word(8);
        exp0 = ref_word(0);
        chk({tag, "_drain"}, 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h0);
        @(posedge clk); #1;
        chk({tag, "_hold_flags"}, 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'hC);
        chk({tag, "_data_s8"}, 64'(out_data_s8), exp8);
        chk({tag, "_data_s0"}, 64'(out_data_s0), exp0);
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_flags"}, 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'hC);
            chk({tag, "_stall_s8"}, 64'(out_data_s8), exp8);
            chk({tag, "_stall_s0"}, 64'(out_data_s0), exp0);
            if (i == hold - 1) out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_release"}, 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h3);
        out_ready = 1'($urandom_range(0, 1));
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        scramble();
        #2;
        chk("reset_async", 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h3);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_flags", 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h3);
        chk("reset_data", 64'({out_data_s8, out_data_s0}), 64'h0);
        rst = 1'b0;
        idle(2);

        // 1: one beat of 256 -> 9 at SHIFT=8, 2304 at SHIFT=0
        set_const(256, 256, 256, 256);
        beat(1'b1, "t1");
        finish_group(0, "t1");

        // 2: one beat of 1
        set_const(1, 1, 1, 1);
        beat(1'b1, "t2");
        finish_group(0, "t2");

        // 3: three channels, opposite-sign lanes
        set_const(100, -100, 0, 0);
        beat(1'b0, "t3a");
        beat(1'b0, "t3b");
        beat(1'b1, "t3c");
        finish_group(1, "t3");

        // 4: saturation at both extremes
        set_const(16777215, -16777216, 0, 1);
        beat(1'b1, "t4");
        finish_group(0, "t4");

        // 5: consumer stalls five cycles, next group follows immediately
        set_const(-3, 5, 1000, -7);
        beat(1'b0, "t5a");
        beat(1'b1, "t5b");
        finish_group(5, "t5");
        set_const(11, 12, 13, 14);
        beat(1'b1, "t5n");
        finish_group(0, "t5n");

        // 6: reset mid-group discards partial sums
        set_const(50, 50, 50, 50);
        beat(1'b0, "t6a");
        beat(1'b0, "t6b");
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_flags", 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h3);
        @(posedge clk); #1;
        chk("t6_rst_hold", 64'({out_valid_s8, out_valid_s0, in_ready_s8, in_ready_s0}), 64'h3);
        rst = 1'b0;
        clear_model();
        set_const(7, 7, 7, 7);
        beat(1'b1, "t6");
        finish_group(0, "t6");

        // Random groups with idle gaps and random stalls
        for (int g = 0; g < 12; g++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                set_rand();
                beat(1'(b == n - 1), $sformatf("r%0d_b%0d", g, b));
                if (b != n - 1) idle($urandom_range(0, 1));
            end
            finish_group($urandom_range(0, 3), $sformatf("r%0d", g));
            idle($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
